// File: rtl/countdown_pkg.sv
// countdown_pkg: shared state encoding and default width for countdown_timer
package countdown_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} countdown_state_t;
    localparam int COUNTDOWN_W_DEFAULT = 10;
endpackage

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with valid/ready load, pause, abort and done pulse (SVA under COUNTDOWN_TIMER_ASSERT_EN)
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int W = COUNTDOWN_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [W-1:0] load_value,
    input  logic         pause,
    input  logic         abort,
    output logic [W-1:0] cnt,
    output logic         busy,
    output logic         done
);
    countdown_state_t r_state, w_state_next;
    logic [W-1:0]     r_cnt, w_cnt_next;
    logic             w_load;
    assign load_ready = (r_state == IDLE) && !abort && !rst;
    assign w_load     = load_valid && load_ready;
    assign cnt        = r_cnt;
    assign busy       = (r_state != IDLE) && !rst;
    assign done       = (r_state == DONE) && !rst;
    // next state and count: abort beats pause beats decrement; the decrement never wraps below zero
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                w_cnt_next   = w_load ? load_value : r_cnt;
                w_state_next = !w_load ? IDLE : (load_value != '0) ? RUN : DONE;
            end
            RUN: begin
                w_cnt_next   = abort ? '0 : pause ? r_cnt : (r_cnt != '0) ? r_cnt - 1'b1 : '0;
                w_state_next = abort ? IDLE : (!pause && r_cnt <= W'(1)) ? DONE : RUN;
            end
            default: begin
                w_cnt_next   = '0;
                w_state_next = IDLE;
            end
        endcase
    end
    // state and count registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end
`ifdef COUNTDOWN_TIMER_ASSERT_EN
    a_no_wrap: assert property (@(posedge clk) disable iff (rst)
        (r_cnt == '1) |-> ($past(r_cnt) == '1 || $past(load_valid && load_ready && load_value == '1)));
    a_done_zero: assert property (@(posedge clk) disable iff (rst) done |-> (r_cnt == '0));
    a_done_pulse: assert property (@(posedge clk) disable iff (rst) done |=> !done);
    a_busy_ready: assert property (@(posedge clk) disable iff (rst) !(busy && load_ready));
    a_pause_hold: assert property (@(posedge clk) disable iff (rst)
        (r_state == RUN && pause && !abort) |=> $stable(r_cnt));
    c_done: cover property (@(posedge clk) disable iff (rst) done);
`endif
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed checks of countdown_timer at W=10
module tb_countdown_timer;
    localparam int W = 10;
    logic         clk = 1'b0;
    logic         rst;
    logic         load_valid;
    logic         load_ready;
    logic [W-1:0] load_value;
    logic         pause;
    logic         abort;
    logic [W-1:0] cnt;
    logic         busy;
    logic         done;
    int           checks = 0;
    int           failures = 0;

    countdown_timer #(.W(W)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .load_value(load_value), .pause(pause), .abort(abort),
        .cnt(cnt), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        logic seen_ones;
        rst = 1'b1; load_valid = 1'b0; load_value = '0; pause = 1'b0; abort = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) step();
        check("rst_ready", load_ready, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        #1;
        check("rel_cnt", cnt, 0);
        check("rel_busy", busy, 0);
        check("rel_done", done, 0);
        check("rel_ready", load_ready, 1);

        load_valid = 1'b1; load_value = 10'd5;
        step();
        load_valid = 1'b0;
        check("b_cnt0", cnt, 5);
        check("b_busy", busy, 1);
        check("b_ready", load_ready, 0);
        for (int k = 1; k <= 5; k++) begin
            step();
            check("b_cnt", cnt, 32'(5 - k));
            check("b_done", done, (k == 5) ? 1 : 0);
        end
        step();
        check("b_done_off", done, 0);
        check("b_ready_back", load_ready, 1);
        check("b_idle", busy, 0);

        load_valid = 1'b1; load_value = 10'd0;
        step();
        load_valid = 1'b0;
        check("z_done", done, 1);
        check("z_busy", busy, 1);
        check("z_cnt", cnt, 0);
        step();
        check("z_done_off", done, 0);
        check("z_busy_off", busy, 0);

        load_valid = 1'b1; load_value = 10'd1023;
        step();
        load_valid = 1'b0;
        check("f_cnt0", cnt, 1023);
        lat = 0;
        seen_ones = 1'b0;
        while (!done && lat < 1100) begin
            step();
            lat++;
            if (cnt == 10'd1023) seen_ones = 1'b1;
        end
        check("f_latency", lat, 1023);
        check("f_nowrap", seen_ones, 0);
        step();
        check("f_ready", load_ready, 1);

        load_valid = 1'b1; load_value = 10'd4;
        step();
        load_valid = 1'b0;
        step();
        step();
        check("p_cnt2", cnt, 2);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("p_hold", cnt, 2);
            check("p_nodone", done, 0);
        end
        pause = 1'b0;
        step();
        check("p_cnt1", cnt, 1);
        check("p_nodone1", done, 0);
        step();
        check("p_cnt0", cnt, 0);
        check("p_done", done, 1);
        step();

        load_valid = 1'b1; load_value = 10'd8;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("a_cnt3", cnt, 3);
        abort = 1'b1;
        #1;
        check("a_ready_run", load_ready, 0);
        step();
        abort = 1'b0;
        #1;
        check("a_cnt", cnt, 0);
        check("a_busy", busy, 0);
        check("a_done", done, 0);
        check("a_ready", load_ready, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("a_nodone", done, 0);
        end

        load_valid = 1'b1; abort = 1'b1; load_value = 10'd7;
        #1;
        check("ai_ready", load_ready, 0);
        step();
        load_valid = 1'b0; abort = 1'b0;
        check("ai_cnt", cnt, 0);
        check("ai_busy", busy, 0);

        load_valid = 1'b1; load_value = 10'd6;
        step();
        load_valid = 1'b0;
        step();
        step();
        check("r_cnt4", cnt, 4);
        rst = 1'b1;
        #1;
        check("r_busy_hi", busy, 0);
        check("r_ready_hi", load_ready, 0);
        step();
        rst = 1'b0;
        #1;
        check("r_cnt", cnt, 0);
        check("r_busy", busy, 0);
        check("r_done", done, 0);
        step();
        check("r_nodone", done, 0);

        load_valid = 1'b1; load_value = 10'd3;
        step();
        check("h_cnt3", cnt, 3);
        load_value = 10'd9;
        step();
        check("h_ign2", cnt, 2);
        step();
        check("h_ign1", cnt, 1);
        step();
        check("h_done", done, 1);
        check("h_ready_done", load_ready, 0);
        step();
        check("h_idle_cnt", cnt, 0);
        check("h_ready_idle", load_ready, 1);
        step();
        load_valid = 1'b0;
        check("h_reload", cnt, 9);
        check("h_busy", busy, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("h_abort", cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
